bsearch_ctrl: RTL

- Sequential controller that drives the probe (b) side of an n-bit magnitude comparator and consumes its agb/aeb/alb flags.
- The comparator's a input carries an unknown target. The controller binary-searches the probe value until aeb is reported, then returns the target value and the step count.
- Lives in the combinational-circuit lab alongside the comparator. It is the consumer side of that comparator's flag interface.

---
 rtl/bsearch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bsearch_ctrl.sv
// Binary-search controller driving the probe side of an n-bit comparator.
// Searches for the comparator's a operand using its agb/aeb/alb flags.
module bsearch_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [N-1:0]  probe,
  input  logic          agb,
  input  logic          aeb,
  input  logic          alb,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [N-1:0]  result,
  output logic [CW-1:0] steps
);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [N-1:0]  result_q, result_d;
  logic          found_q, found_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [2:0]    flags;
  logic          onehot;

  assign probe  = lo_q + ((hi_q - lo_q) >> 1);
  assign flags  = {agb, aeb, alb};
  assign onehot = (flags == 3'b100) ||
                  (flags == 3'b010) ||
                  (flags == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      steps_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      steps_q  <= steps_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    steps_d  = steps_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          steps_d  = '0;
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        steps_d  = steps_q + CW'(1);
        if (!onehot) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = probe;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          // Exhausted checks guard the +1/-1 against wrap.
          unique case (1'b1)
            aeb: begin
              found_d  = 1'b1;
              result_d = probe;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
            agb: begin
              if (probe == hi_q) begin
                found_d  = 1'b0;
                result_d = probe;
                done_d   = 1'b1;
                state_d  = IDLE;
              end else begin
                lo_d = probe + N'(1);
              end
            end
            alb: begin
              if (probe == lo_q) begin
                found_d  = 1'b0;
                result_d = probe;
                done_d   = 1'b1;
                state_d  = IDLE;
              end else begin
                hi_d = probe - N'(1);
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SEARCH);
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule
